// File: rtl/monitor_verdict_collector.sv
// Monitor verdict collector: captures strobed result streams into a pending frame, then serialises each
// updated stream as a timestamped {idx,data,ts} record into a show-ahead FIFO. Option: COLLECTOR_CHANGE_FILTER_EN.
module monitor_verdict_collector #(
   parameter int NUM_STREAMS = 12,
   parameter int DATA_W      = 32,
   parameter int TS_W        = 32,
   parameter int FIFO_DEPTH  = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          en,
   input  logic [NUM_STREAMS*DATA_W-1:0] result_i,
   input  logic [NUM_STREAMS-1:0]        upd_i,
   output logic                          rec_valid,
   input  logic                          rec_ready,
   output logic [$clog2(NUM_STREAMS)-1:0] rec_idx,
   output logic signed [DATA_W-1:0]     rec_data,
   output logic [TS_W-1:0]               rec_ts,
   output logic                          overflow,
   output logic [15:0]                   drop_cnt
);
   localparam int IDX_W = $clog2(NUM_STREAMS);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {IDLE, LOAD, SCAN} state_t;
   typedef struct packed {
      logic [IDX_W-1:0]  idx;
      logic [DATA_W-1:0] data;
      logic [TS_W-1:0]   ts;
   } rec_t;

   logic [TS_W-1:0]               ts_q;
   logic                          pend_vld_q;
   logic [NUM_STREAMS-1:0]        pend_mask_q;
   logic [NUM_STREAMS*DATA_W-1:0] pend_vals_q;
   logic [TS_W-1:0]               pend_ts_q;
   state_t                        state_q, state_d;
   logic [NUM_STREAMS-1:0]        work_mask_q, work_mask_d;
   logic [NUM_STREAMS*DATA_W-1:0] work_vals_q, work_vals_d;
   logic [TS_W-1:0]               work_ts_q, work_ts_d;
   rec_t                          mem [FIFO_DEPTH];
   logic [PTR_W-1:0]              wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]              cnt_q, cnt_d;
   logic                          overflow_q;
   logic [15:0]                   drop_cnt_q;

   logic             capture, pend_take, push, pop, fifo_full, skip, last_bit;
   logic [IDX_W-1:0] sel_idx;
   logic [DATA_W-1:0] sel_val;
   rec_t             rd_rec;

   assign capture   = en && (|upd_i);
   assign fifo_full = (cnt_q == CNT_W'(FIFO_DEPTH));
   assign pop       = rec_valid && rec_ready;
   assign cnt_d     = cnt_q + CNT_W'(push) - CNT_W'(pop);
   assign last_bit  = ((work_mask_q & (work_mask_q - 1'b1)) == '0);

   // Lowest set bit wins, giving ascending stream order within a frame.
   always_comb begin
      sel_idx = '0;
      for (int k = NUM_STREAMS - 1; k >= 0; k--) begin
         if (work_mask_q[k]) sel_idx = IDX_W'(k);
      end
   end
   assign sel_val = work_vals_q[int'(sel_idx)*DATA_W +: DATA_W];

`ifdef COLLECTOR_CHANGE_FILTER_EN
   logic [DATA_W-1:0]      last_val_q [NUM_STREAMS];
   logic [NUM_STREAMS-1:0] last_vld_q;

   assign skip = (state_q == SCAN) && last_vld_q[sel_idx] && (last_val_q[sel_idx] == sel_val);

   always_ff @(posedge clk) begin
      if (rst) begin
         last_vld_q <= '0;
         for (int k = 0; k < NUM_STREAMS; k++) last_val_q[k] <= '0;
      end else if (push) begin
         last_vld_q[sel_idx] <= 1'b1;
         last_val_q[sel_idx] <= sel_val;
      end
   end
`else
   assign skip = 1'b0;
`endif

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      state_d     = state_q;
      work_mask_d = work_mask_q;
      work_vals_d = work_vals_q;
      work_ts_d   = work_ts_q;
      pend_take   = 1'b0;
      push        = 1'b0;
      if (en) begin
         case (state_q)
            IDLE: begin
               // A pending frame waits while the FIFO is full so it is never lost from the pending slot.
               if (pend_vld_q && !fifo_full) begin
                  pend_take   = 1'b1;
                  work_mask_d = pend_mask_q;
                  work_vals_d = pend_vals_q;
                  work_ts_d   = pend_ts_q;
                  state_d     = LOAD;
               end
            end
            LOAD: state_d = SCAN;
            SCAN: begin
               if (skip || !fifo_full || pop) begin
                  push                 = !skip;
                  work_mask_d[sel_idx] = 1'b0;
                  if (last_bit) begin
                     state_d = IDLE;
                     if (pend_vld_q && (cnt_q + CNT_W'(!skip) - CNT_W'(pop)) != CNT_W'(FIFO_DEPTH)) begin
                        pend_take   = 1'b1;
                        work_mask_d = pend_mask_q;
                        work_vals_d = pend_vals_q;
                        work_ts_d   = pend_ts_q;
                        state_d     = LOAD;
                     end
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ts_q        <= '0;
         pend_vld_q  <= 1'b0;
         pend_mask_q <= '0;
         pend_vals_q <= '0;
         pend_ts_q   <= '0;
         state_q     <= IDLE;
         work_mask_q <= '0;
         work_vals_q <= '0;
         work_ts_q   <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         cnt_q       <= '0;
         overflow_q  <= 1'b0;
         drop_cnt_q  <= '0;
      end else begin
         if (en) ts_q <= ts_q + 1'b1;
         if (capture) begin
            if (!pend_vld_q || pend_take) begin
               pend_vld_q  <= 1'b1;
               pend_mask_q <= upd_i;
               pend_vals_q <= result_i;
               pend_ts_q   <= ts_q;
            end else begin
               overflow_q <= 1'b1;
               if (drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
            end
         end else if (pend_take) begin
            pend_vld_q <= 1'b0;
         end
         state_q     <= state_d;
         work_mask_q <= work_mask_d;
         work_vals_q <= work_vals_d;
         work_ts_q   <= work_ts_d;
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         cnt_q <= cnt_d;
      end
   end

   // NOTE: storage is not reset; pointers and count define validity, and outputs are masked when empty.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_q] <= '{idx: sel_idx, data: sel_val, ts: work_ts_q};
   end

   assign rd_rec    = mem[rd_ptr_q];
   assign rec_valid = (cnt_q != '0);
   assign rec_idx   = rec_valid ? rd_rec.idx  : '0;
   assign rec_data  = rec_valid ? rd_rec.data : '0;
   assign rec_ts    = rec_valid ? rd_rec.ts   : '0;
   assign overflow  = overflow_q;
   assign drop_cnt  = drop_cnt_q;
endmodule
